// File: rtl/load_merge_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_merge_unit_pkg
// Description : Shared definitions for the memory-stage load return path:
//               load size encodings, opcode-to-size mapping, the split
//               (misalignment) condition shared with the execute stage, and
//               the merge FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package load_merge_unit_pkg;

  // Load size encodings (req_size). Encoding 3 is reserved and behaves as word.
  localparam logic [1:0] SZ_WORD   = 2'd0;
  localparam logic [1:0] SZ_DOUBLE = 2'd1;
  localparam logic [1:0] SZ_BYTE   = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } lmu_state_e;

  // Load opcode to access size: 3-5 word, 6-8 double, 9-11 byte.
  function automatic logic [1:0] opcode_to_size(input logic [3:0] opcode);
    case (opcode)
      4'd3, 4'd4, 4'd5:  return SZ_WORD;
      4'd6, 4'd7, 4'd8:  return SZ_DOUBLE;
      4'd9, 4'd10, 4'd11: return SZ_BYTE;
      default:           return SZ_WORD;
    endcase
  endfunction

  // An access is split into two beats when it crosses a word boundary.
  function automatic logic is_split(input logic [1:0] size, input logic [1:0] k);
    case (size)
      SZ_DOUBLE: return (k == 2'd3);
      SZ_BYTE:   return 1'b0;
      default:   return (k != 2'd0);
    endcase
  endfunction

  // Byte offset to bit shift. Kept at 6 bits so 32 is representable when
  // the upper-piece shift is computed as 32 - 8k.
  function automatic logic [5:0] lane_shift(input logic [1:0] k);
    return {1'b0, k, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_merge_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_merge_unit_if
// Description : Load return bus between the memory stage control and the
//               load merge unit.
//               Request side : req_valid, req_is_load, req_size, req_addr_lo,
//                              req_second, req_tgt, rdata
//               Result side  : result, result_valid, result_tgt, holding,
//                              seq_err
//               master drives requests / sees results; slave is the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_merge_unit_if;
  logic        req_valid;
  logic        req_is_load;
  logic [1:0]  req_size;
  logic [1:0]  req_addr_lo;
  logic        req_second;
  logic [4:0]  req_tgt;
  logic [31:0] rdata;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  result_tgt;
  logic        holding;
  logic        seq_err;

  modport master (
    output req_valid, req_is_load, req_size, req_addr_lo, req_second,
           req_tgt, rdata,
    input  result, result_valid, result_tgt, holding, seq_err
  );

  modport slave (
    input  req_valid, req_is_load, req_size, req_addr_lo, req_second,
           req_tgt, rdata,
    output result, result_valid, result_tgt, holding, seq_err
  );
endinterface
`default_nettype wire

// File: rtl/load_merge_unit_lane_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_merge_unit_lane_extract
// Description : Combinational lane extraction: shifts the word right by k
//               bytes, masks to the access size and zero/sign extends.
//               Ports: word (32) in, k (2) in, size (2) in, sign_ext (1) in,
//                      value (32) out.
// Revision    : 1.0 - initial release
// ============================================================================
module load_merge_unit_lane_extract
  import load_merge_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  k,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] value
);

  logic [31:0] w_shifted;

  assign w_shifted = word >> lane_shift(k);

  always_comb begin
    value = w_shifted;
    case (size)
      SZ_DOUBLE: value = {{16{sign_ext & w_shifted[15]}}, w_shifted[15:0]};
      SZ_BYTE:   value = {{24{sign_ext & w_shifted[7]}},  w_shifted[7:0]};
      default:   value = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_merge_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_merge_unit
// Description : Memory-stage load return path. Extracts and extends the
//               addressed bytes of word/double/byte loads and reassembles
//               loads that were split into two beats (aligned base, then
//               base+4). Result is registered, one cycle after the
//               completing beat.
//               Ports: clk, rst_n (async active-low), clk_en (stall enable),
//                      flush (drops a held first piece), bus (slave side of
//                      load_merge_unit_if).
// Revision    : 1.0 - initial release
// ============================================================================
module load_merge_unit
  import load_merge_unit_pkg::*;
#(
  parameter bit SIGN_EXT  = 1'b0,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   flush,
  load_merge_unit_if.slave       bus
);

  lmu_state_e  r_state, w_state_nx;
  logic [31:0] r_buf, w_buf_nx;
  logic [31:0] r_result, w_result_nx;
  logic        r_valid, w_valid_nx;
  logic [4:0]  r_tgt, w_tgt_nx;
  logic        r_seq_err, w_seq_err_nx;

  logic        w_live;
  logic        w_split;
  logic        w_seq_en;
  logic [1:0]  w_k;
  logic [31:0] w_base;
  logic [5:0]  w_hi_shift;
  logic [31:0] w_merged;
  logic [31:0] w_ext_word;
  logic [1:0]  w_ext_k;
  logic [31:0] w_value;
  logic [31:0] w_first_piece;

  generate
    if (CHECK_SEQ) begin : g_seq_on
      assign w_seq_en = 1'b1;
    end else begin : g_seq_off
      assign w_seq_en = 1'b0;
    end
  endgenerate

  assign w_k     = bus.req_addr_lo;
  assign w_live  = bus.req_valid & bus.req_is_load & ~flush;
  assign w_split = is_split(bus.req_size, w_k);

  // Out of HOLD the merge sees an all-zero first piece, so an orphan second
  // beat still produces a defined (upper-bytes-only) value.
  assign w_base     = (r_state == ST_HOLD) ? r_buf : 32'd0;
  // k = 0 gives a shift of 32, which clears the second beat entirely.
  assign w_hi_shift = 6'd32 - lane_shift(w_k);
  assign w_merged   = w_base | (bus.rdata << w_hi_shift);

  // The merged word is already lane-aligned, so it goes through the
  // extractor with k = 0; a single-beat load uses the raw word and its k.
  assign w_ext_word = bus.req_second ? w_merged : bus.rdata;
  assign w_ext_k    = bus.req_second ? 2'd0 : w_k;

  assign w_first_piece = bus.rdata >> lane_shift(w_k);

  load_merge_unit_lane_extract u_extract (
    .word     (w_ext_word),
    .k        (w_ext_k),
    .size     (bus.req_size),
    .sign_ext (SIGN_EXT),
    .value    (w_value)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_buf_nx     = r_buf;
    w_result_nx  = r_result;
    w_valid_nx   = 1'b0;
    w_tgt_nx     = 5'd0;
    w_seq_err_nx = 1'b0;

    if (flush) begin
      w_state_nx = ST_IDLE;
      w_buf_nx   = 32'd0;
    end else if (w_live) begin
      if (bus.req_second) begin
        w_result_nx  = w_value;
        w_valid_nx   = 1'b1;
        w_tgt_nx     = bus.req_tgt;
        w_seq_err_nx = w_seq_en & (r_state == ST_IDLE);
        w_state_nx   = ST_IDLE;
        w_buf_nx     = 32'd0;
      end else begin
        // A new first beat while holding discards the old piece.
        w_seq_err_nx = w_seq_en & (r_state == ST_HOLD);
        if (w_split) begin
          w_buf_nx   = w_first_piece;
          w_state_nx = ST_HOLD;
        end else begin
          w_result_nx = w_value;
          w_valid_nx  = 1'b1;
          w_tgt_nx    = bus.req_tgt;
          w_state_nx  = ST_IDLE;
          w_buf_nx    = 32'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_buf     <= 32'd0;
      r_result  <= 32'd0;
      r_valid   <= 1'b0;
      r_tgt     <= 5'd0;
      r_seq_err <= 1'b0;
    end else if (clk_en) begin
      r_state   <= w_state_nx;
      r_buf     <= w_buf_nx;
      r_result  <= w_result_nx;
      r_valid   <= w_valid_nx;
      r_tgt     <= w_tgt_nx;
      r_seq_err <= w_seq_err_nx;
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;
  assign bus.result_tgt   = r_tgt;
  assign bus.holding      = (r_state == ST_HOLD);
  assign bus.seq_err      = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_load_merge_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_merge_unit
// Description : Self-checking bench for load_merge_unit. Two instances
//               (zero- and sign-extending) share one stimulus stream and are
//               checked every cycle against a byte-level reference model;
//               directed steps pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_merge_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_load = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [1:0]  req_addr_lo = 2'd0;
  logic        req_second = 1'b0;
  logic [4:0]  req_tgt = 5'd0;
  logic [31:0] rdata = 32'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_merge_unit_if bus0 ();
  load_merge_unit_if bus1 ();

  assign bus0.req_valid   = req_valid;
  assign bus0.req_is_load = req_is_load;
  assign bus0.req_size    = req_size;
  assign bus0.req_addr_lo = req_addr_lo;
  assign bus0.req_second  = req_second;
  assign bus0.req_tgt     = req_tgt;
  assign bus0.rdata       = rdata;
  assign bus1.req_valid   = req_valid;
  assign bus1.req_is_load = req_is_load;
  assign bus1.req_size    = req_size;
  assign bus1.req_addr_lo = req_addr_lo;
  assign bus1.req_second  = req_second;
  assign bus1.req_tgt     = req_tgt;
  assign bus1.rdata       = rdata;

  load_merge_unit #(.SIGN_EXT(1'b0), .CHECK_SEQ(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .bus(bus0)
  );
  load_merge_unit #(.SIGN_EXT(1'b1), .CHECK_SEQ(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .bus(bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-stream view) ----------------
  bit          m_hold = 1'b0;
  logic [1:0]  m_k = 2'd0;
  logic [7:0]  m_held[$];
  logic [31:0] m_res0 = 32'd0, m_res1 = 32'd0;
  bit          m_valid = 1'b0, m_err = 1'b0;
  logic [4:0]  m_tgt = 5'd0;

  function automatic logic [31:0] extend(input logic [31:0] raw, input int n, input bit sgn);
    if (n == 2) return (sgn && raw[15]) ? {16'hFFFF, raw[15:0]} : {16'h0000, raw[15:0]};
    if (n == 1) return (sgn && raw[7]) ? {24'hFFFFFF, raw[7:0]} : {24'h000000, raw[7:0]};
    return raw;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0]  stream[$];
    logic [31:0] raw;
    int          n;
    bit          produce;
    bit          needs_split;
    if (!rst_n) begin
      m_hold = 0; m_held = {}; m_res0 = 0; m_res1 = 0;
      m_valid = 0; m_err = 0; m_tgt = 0;
    end else if (clk_en) begin
      m_valid = 0; m_tgt = 0; m_err = 0; produce = 0;
      n = (req_size == 2'd1) ? 2 : (req_size == 2'd2) ? 1 : 4;
      stream = {};
      if (flush) begin
        m_hold = 0; m_held = {};
      end else if (req_valid && req_is_load) begin
        if (req_second) begin
          // first piece (or zeros standing in for it) then the new word
          if (m_hold) stream = m_held;
          else for (int i = 0; i < 4 - int'(req_addr_lo); i++) stream.push_back(8'h00);
          for (int i = 0; i < 4; i++) stream.push_back(rdata[8*i +: 8]);
          m_err = !m_hold;
          m_hold = 0; m_held = {};
          produce = 1;
        end else begin
          m_err = m_hold;
          needs_split = (n == 4 && req_addr_lo != 0) || (n == 2 && req_addr_lo == 3);
          m_held = {};
          if (needs_split) begin
            for (int i = int'(req_addr_lo); i < 4; i++) m_held.push_back(rdata[8*i +: 8]);
            m_hold = 1; m_k = req_addr_lo;
          end else begin
            for (int i = int'(req_addr_lo); i < 4; i++) stream.push_back(rdata[8*i +: 8]);
            m_hold = 0;
            produce = 1;
          end
        end
        if (produce) begin
          raw = 32'd0;
          for (int i = 0; i < n; i++) raw[8*i +: 8] = stream[i];
          m_res0 = extend(raw, n, 1'b0);
          m_res1 = extend(raw, n, 1'b1);
          m_valid = 1; m_tgt = req_tgt;
        end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    check("d0.result", bus0.result, m_res0);
    check("d0.valid", {31'd0, bus0.result_valid}, {31'd0, m_valid});
    check("d0.tgt", {27'd0, bus0.result_tgt}, {27'd0, m_tgt});
    check("d0.holding", {31'd0, bus0.holding}, {31'd0, m_hold});
    check("d0.seq_err", {31'd0, bus0.seq_err}, {31'd0, m_err});
    check("d1.result", bus1.result, m_res1);
    check("d1.valid", {31'd0, bus1.result_valid}, {31'd0, m_valid});
    check("d1.tgt", {27'd0, bus1.result_tgt}, {27'd0, m_tgt});
    check("d1.holding", {31'd0, bus1.holding}, {31'd0, m_hold});
    check("d1.seq_err", {31'd0, bus1.seq_err}, {31'd0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic beat(input bit v, input bit ld, input logic [1:0] sz, input logic [1:0] k,
                      input bit sec, input logic [4:0] tgt, input logic [31:0] d);
    req_valid = v; req_is_load = ld; req_size = sz; req_addr_lo = k;
    req_second = sec; req_tgt = tgt; rdata = d;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("lit.reset_result", bus0.result, 32'h0);
    check("lit.reset_valid", {31'd0, bus0.result_valid}, 32'd0);
    check("lit.reset_holding", {31'd0, bus0.holding}, 32'd0);
    rst_n = 1'b1; clk_en = 1'b1;

    // aligned word
    beat(1, 1, 2'd0, 2'd0, 0, 5'd5, 32'h44332211);
    check("lit.word", bus0.result, 32'h44332211);
    check("lit.word_valid", {31'd0, bus0.result_valid}, 32'd1);
    check("lit.word_tgt", {27'd0, bus0.result_tgt}, 32'd5);

    // bytes
    beat(1, 1, 2'd2, 2'd2, 0, 5'd6, 32'h44332211);
    check("lit.byte", bus0.result, 32'h00000033);
    beat(1, 1, 2'd2, 2'd2, 0, 5'd6, 32'h44B32211);
    check("lit.byte_sext", bus1.result, 32'hFFFFFFB3);
    check("lit.byte_zext", bus0.result, 32'h000000B3);

    // split word at k=1
    beat(1, 1, 2'd0, 2'd1, 0, 5'd7, 32'h44332211);
    check("lit.split_hold", {31'd0, bus0.holding}, 32'd1);
    check("lit.split_novalid", {31'd0, bus0.result_valid}, 32'd0);
    beat(1, 1, 2'd0, 2'd1, 1, 5'd7, 32'h88776655);
    check("lit.split_word", bus0.result, 32'h55443322);
    check("lit.split_valid", {31'd0, bus0.result_valid}, 32'd1);
    beat(0, 0, 2'd0, 2'd0, 0, 5'd0, 32'h0);
    check("lit.split_once", {31'd0, bus0.result_valid}, 32'd0);

    // split double at k=3 with a bubble
    beat(1, 1, 2'd1, 2'd3, 0, 5'd8, 32'h44332211);
    beat(0, 0, 2'd0, 2'd0, 0, 5'd0, 32'h0);
    check("lit.bubble_hold", {31'd0, bus0.holding}, 32'd1);
    beat(1, 1, 2'd1, 2'd3, 1, 5'd8, 32'h88776655);
    check("lit.split_double", bus0.result, 32'h00005544);

    // clk_en freeze during HOLD
    beat(1, 1, 2'd0, 2'd1, 0, 5'd9, 32'h44332211);
    clk_en = 1'b0;
    beat(1, 1, 2'd0, 2'd1, 1, 5'd9, 32'h88776655);
    check("lit.freeze_hold", {31'd0, bus0.holding}, 32'd1);
    check("lit.freeze_novalid", {31'd0, bus0.result_valid}, 32'd0);
    clk_en = 1'b1;
    beat(1, 1, 2'd0, 2'd1, 1, 5'd9, 32'h88776655);
    check("lit.freeze_merge", bus0.result, 32'h55443322);

    // flush while holding
    beat(1, 1, 2'd0, 2'd1, 0, 5'd10, 32'h44332211);
    flush = 1'b1;
    beat(1, 1, 2'd0, 2'd0, 0, 5'd10, 32'h12345678);
    flush = 1'b0;
    check("lit.flush_hold", {31'd0, bus0.holding}, 32'd0);
    check("lit.flush_novalid", {31'd0, bus0.result_valid}, 32'd0);
    beat(1, 1, 2'd0, 2'd0, 0, 5'd11, 32'hDEADBEEF);
    check("lit.after_flush", bus0.result, 32'hDEADBEEF);
    check("lit.after_flush_err", {31'd0, bus0.seq_err}, 32'd0);
    beat(1, 1, 2'd0, 2'd1, 1, 5'd12, 32'h88776655);
    check("lit.orphan_err", {31'd0, bus0.seq_err}, 32'd1);
    check("lit.orphan_result", bus0.result, 32'h55000000);

    // async reset while holding
    beat(1, 1, 2'd0, 2'd1, 0, 5'd13, 32'h44332211);
    #2 rst_n = 1'b0;
    #1;
    check("lit.arst_holding", {31'd0, bus0.holding}, 32'd0);
    check("lit.arst_result", bus0.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 1, 2'd0, 2'd1, 1, 5'd13, 32'h88776655);
    check("lit.arst_seq_err", {31'd0, bus0.seq_err}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clk_en      = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      req_valid   = ($urandom_range(0, 4) != 0);
      req_is_load = ($urandom_range(0, 6) != 0);
      req_size    = 2'($urandom_range(0, 3));
      req_addr_lo = 2'($urandom_range(0, 3));
      if (m_hold) begin
        req_second = ($urandom_range(0, 3) != 0);
        if (req_second) req_addr_lo = m_k;
      end else begin
        req_second = ($urandom_range(0, 4) == 0);
      end
      req_tgt = 5'($urandom);
      rdata   = $urandom;
      rst_n   = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end

    rst_n = 1'b1; clk_en = 1'b1; flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
